beta_fetch: RTL

Instruction-fetch and program-counter unit for the Beta core. It is the supplier end of the control unit's instruction/PCSEL interface. It fetches each instruction from instruction memory over a req/ack handshake, holds it stable for the control unit, and waits for the commit strobe. It then computes the next PC from the control unit's `pcsel` and fetches again. It owns the PC, including supervisor bit PC[31].

---
 rtl/beta_fetch.sv | 96 +++++++++
 1 files changed

// File: rtl/beta_fetch.sv
// rtl/beta_fetch.sv - Beta instruction-fetch and PC unit
// Fetches over req/ack, holds the word for the control unit, advances PC on commit.
module beta_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pcsel,
    input  logic [31:0] jt,
    input  logic        exec_done,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // A JMP may drop supervisor mode but can never enter it.
    always_comb begin
        next_pc_raw = ILLOP_PC;
        case (pcsel)
            3'd0:    next_pc_raw = pc4;
            3'd1:    next_pc_raw = pc4 + br_off;
            3'd2:    next_pc_raw = {pc_q[31] & jt[31], jt[30:0]};
            3'd4:    next_pc_raw = XADR_PC;
            default: next_pc_raw = ILLOP_PC;
        endcase
    end

    assign next_pc = {next_pc_raw[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (exec_done) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    // req decodes the async-reset state register, so reset drops it at once.
    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_HOLD);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc4;
    assign instr       = instr_q;

endmodule
